// File: rtl/round_key_sequencer.sv
// Round key sequencer: reads expanded AES-128 round keys from the key generator's
//   store and hands them, one at a time, to the round datapath (ascending 0..NR for
//   encryption, descending NR..0 for decryption).
// Latency: start -> first key_valid is 3 cycles when generation_done is already high;
//   default build delivers 1 key per 3 cycles, prefetch build 1 key per cycle.
// Backpressure: key_out/key_round/key_last hold while key_valid=1 and key_ready=0;
//   start is ignored while busy.
//
// Optional feature macro: KEYSEQ_PREFETCH_EN (2-entry key buffer with read-ahead).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, decrypt      begin a sequence; order bit sampled with start
//   generation_done     key store holds a complete schedule; dropping it aborts
//   read_addr           key store read address (store answers one cycle later)
//   round_key_0         original key, used for index 0
//   round_key_x         registered key store data for read_addr
//   key_out, key_round  key and its round index, qualified by key_valid
//   key_valid/key_ready handshake to the round datapath
//   key_last            key_out is the final key of the sequence
//   busy, seq_done      sequence in progress / one-cycle pulse after last handshake
//   abort               one-cycle pulse when generation_done drops mid-sequence
module round_key_sequencer #(
    parameter int NR     = 10,
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              decrypt,
    input  logic              generation_done,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [KEY_W-1:0]  round_key_0,
    input  logic [KEY_W-1:0]  round_key_x,
    output logic [KEY_W-1:0]  key_out,
    output logic [ADDR_W-1:0] key_round,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_last,
    output logic              busy,
    output logic              seq_done,
    output logic              abort
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_GEN = 3'd1;
    localparam logic [2:0] FETCH    = 3'd2;
    localparam logic [2:0] LOAD     = 3'd3;
    localparam logic [2:0] PRESENT  = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    localparam logic [ADDR_W-1:0] NR_IDX = ADDR_W'(NR);

    logic [2:0]        state;
    logic              desc;        // order latched at start
    logic [ADDR_W-1:0] start_idx;   // first index for the order requested by start
    logic [ADDR_W-1:0] fin_idx;     // last index for the latched order

    // Saturating step towards the end of the sequence; never wraps.
    function automatic logic [ADDR_W-1:0] step_idx(input logic [ADDR_W-1:0] i,
                                                   input logic              dn);
        logic [ADDR_W-1:0] r;
        if (dn) r = (i == '0) ? '0 : i - ADDR_W'(1);
        else    r = (i == NR_IDX) ? NR_IDX : i + ADDR_W'(1);
        return r;
    endfunction

    always_comb begin
        start_idx = decrypt ? NR_IDX : '0;
        fin_idx   = desc ? '0 : NR_IDX;
    end

`ifdef KEYSEQ_PREFETCH_EN

    // Read pipeline: p1 = address on read_addr this cycle, p2 = round_key_x holds
    // that key this cycle. Captured keys go to key_out directly when it can take
    // them, otherwise into a 2-entry buffer (head at entry 0).
    logic              p1_vld;
    logic              p2_vld;
    logic [ADDR_W-1:0] p2_idx;
    logic [ADDR_W-1:0] iss_idx;     // next index to read
    logic              iss_end;     // final index already issued
    logic [KEY_W-1:0]  buf_key [2];
    logic [ADDR_W-1:0] buf_idx [2];
    logic [1:0]        buf_cnt;

    logic              streaming;
    logic [KEY_W-1:0]  cap_key;
    logic              can_take;
    logic              load;
    logic              pop;
    logic              push;
    logic              issue;
    logic [KEY_W-1:0]  ld_key;
    logic [ADDR_W-1:0] ld_idx;
    logic [2:0]        pending;
    logic [1:0]        wr_pos;

    always_comb begin
        streaming = (state == PRESENT) && generation_done;
        cap_key   = (p2_idx == '0) ? round_key_0 : round_key_x;
        can_take  = !key_valid || key_ready;
        load      = streaming && can_take && ((buf_cnt != 2'd0) || p2_vld);
        pop       = load && (buf_cnt != 2'd0);
        // The captured key bypasses the buffer only when the buffer is empty.
        push      = streaming && p2_vld && !(load && (buf_cnt == 2'd0));
        ld_key    = (buf_cnt != 2'd0) ? buf_key[0] : cap_key;
        ld_idx    = (buf_cnt != 2'd0) ? buf_idx[0] : p2_idx;
        // Keys read but not yet in key_out; capped at 2 so the buffer never overflows.
        pending   = {2'b00, p1_vld} + {2'b00, p2_vld} + {1'b0, buf_cnt};
        issue     = !iss_end &&
                    ((streaming && ((pending - {2'b00, load}) <= 3'd1)) ||
                     ((state == WAIT_GEN) && generation_done));
        wr_pos    = buf_cnt - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            desc       <= 1'b0;
            read_addr  <= '0;
            key_out    <= '0;
            key_round  <= '0;
            key_valid  <= 1'b0;
            key_last   <= 1'b0;
            busy       <= 1'b0;
            seq_done   <= 1'b0;
            abort      <= 1'b0;
            p1_vld     <= 1'b0;
            p2_vld     <= 1'b0;
            p2_idx     <= '0;
            iss_idx    <= '0;
            iss_end    <= 1'b0;
            buf_key[0] <= '0;
            buf_key[1] <= '0;
            buf_idx[0] <= '0;
            buf_idx[1] <= '0;
            buf_cnt    <= 2'd0;
        end else begin
            seq_done <= 1'b0;
            abort    <= 1'b0;

            p2_vld <= p1_vld;
            p2_idx <= read_addr;
            p1_vld <= 1'b0;

            if (issue) begin
                read_addr <= iss_idx;
                p1_vld    <= 1'b1;
                if (iss_idx == fin_idx) iss_end <= 1'b1;
                else                    iss_idx <= step_idx(iss_idx, desc);
            end

            if (pop) begin
                buf_key[0] <= buf_key[1];
                buf_idx[0] <= buf_idx[1];
            end
            // Written after the shift so a pop+push with one entry lands in entry 0.
            if (push) begin
                buf_key[wr_pos[0]] <= cap_key;
                buf_idx[wr_pos[0]] <= p2_idx;
            end
            buf_cnt <= buf_cnt - {1'b0, pop} + {1'b0, push};

            if (load) begin
                key_out   <= ld_key;
                key_round <= ld_idx;
                key_last  <= (ld_idx == fin_idx);
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        desc    <= decrypt;
                        busy    <= 1'b1;
                        iss_end <= 1'b0;
                        if (generation_done) begin
                            // First read goes out on the start edge.
                            read_addr <= start_idx;
                            p1_vld    <= 1'b1;
                            iss_idx   <= step_idx(start_idx, decrypt);
                            state     <= PRESENT;
                        end else begin
                            iss_idx <= start_idx;
                            state   <= WAIT_GEN;
                        end
                    end
                end
                WAIT_GEN: begin
                    if (generation_done) state <= PRESENT;
                end
                PRESENT: begin
                    if (!generation_done) begin
                        abort     <= 1'b1;
                        busy      <= 1'b0;
                        key_valid <= 1'b0;
                        p1_vld    <= 1'b0;
                        p2_vld    <= 1'b0;
                        buf_cnt   <= 2'd0;
                        state     <= IDLE;
                    end else if (key_valid && key_ready && key_last) begin
                        seq_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`else

    logic [ADDR_W-1:0] idx;

    // read_addr is loaded on the edge that enters FETCH, so it equals idx during
    // FETCH; the store registers that key at the end of FETCH and LOAD samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            desc      <= 1'b0;
            idx       <= '0;
            read_addr <= '0;
            key_out   <= '0;
            key_round <= '0;
            key_valid <= 1'b0;
            key_last  <= 1'b0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            abort    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        desc <= decrypt;
                        idx  <= start_idx;
                        busy <= 1'b1;
                        if (generation_done) begin
                            read_addr <= start_idx;
                            state     <= FETCH;
                        end else begin
                            state <= WAIT_GEN;
                        end
                    end
                end
                WAIT_GEN: begin
                    if (generation_done) begin
                        read_addr <= idx;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!generation_done) begin
                        abort <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!generation_done) begin
                        abort <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        key_out   <= (idx == '0) ? round_key_0 : round_key_x;
                        key_round <= idx;
                        key_last  <= (idx == fin_idx);
                        key_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (!generation_done) begin
                        abort     <= 1'b1;
                        busy      <= 1'b0;
                        key_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (key_valid && key_ready) begin
                        key_valid <= 1'b0;
                        if (key_last) begin
                            seq_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            idx       <= step_idx(idx, desc);
                            read_addr <= step_idx(idx, desc);
                            state     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_round_key_sequencer.sv
module tb_round_key_sequencer;

    localparam logic [127:0] K0 = 128'h7468697369737468656b657930303030;
`ifdef KEYSEQ_PREFETCH_EN
    localparam int LAST_HS_CYC = 13;
`else
    localparam int LAST_HS_CYC = 33;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         decrypt;
    logic         generation_done;
    logic [3:0]   read_addr;
    logic [127:0] round_key_0;
    logic [127:0] round_key_x;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         key_ready;
    logic         key_last;
    logic         busy;
    logic         seq_done;
    logic         abort;

    round_key_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
        .generation_done(generation_done), .read_addr(read_addr),
        .round_key_0(round_key_0), .round_key_x(round_key_x),
        .key_out(key_out), .key_round(key_round), .key_valid(key_valid),
        .key_ready(key_ready), .key_last(key_last), .busy(busy),
        .seq_done(seq_done), .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key store model: registered read, one cycle after the address.
    always_ff @(posedge clk) round_key_x <= {16{4'h0, read_addr}};
    assign round_key_0 = K0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         dec;
        int           pos;
        logic [3:0]   round;
        logic [127:0] key;
        logic         last;
    } vec_t;
    vec_t vt[8];

    // Results of the last run_seq call.
    logic [127:0] got_key[16];
    logic [3:0]   got_round[16];
    logic         got_last[16];
    int n_hs, first_valid, last_hs, n_done, n_abort, stall_bad, stall_seen;
    int drop_cyc, abort_cyc, abort_kv, abort_busy, valid_late, busy_c1, finished;

    // Starts a sequence and runs it to seq_done/abort plus a short tail.
    // stall_round: hold key_ready low 5 cycles on that round (pulse start mid-stall).
    // drop_round: drop generation_done while that round is presented.
    task automatic run_seq(input logic dec, input int stall_round, input int drop_round);
        int cyc, stall_left, tail;
        logic ended;
        logic [127:0] held_key;
        logic [3:0]   held_round;
        n_hs = 0; first_valid = -1; last_hs = -1; n_done = 0; n_abort = 0;
        stall_bad = 0; stall_seen = 0; drop_cyc = -1; abort_cyc = -1;
        abort_kv = -1; abort_busy = -1; valid_late = 0; busy_c1 = 0;
        held_key = '0; held_round = '0;
        @(negedge clk);
        decrypt = dec; start = 1'b1; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; stall_left = 0; tail = 0; ended = 1'b0;
        while (cyc < 300 && tail < 4) begin
            if (cyc == 1) busy_c1 = int'(busy);
            if (ended) begin
                tail++;
                if (key_valid) valid_late++;
            end
            if (seq_done) n_done++;
            if (abort) begin
                n_abort++;
                abort_cyc = cyc; abort_kv = int'(key_valid); abort_busy = int'(busy);
            end
            if (seq_done || abort) ended = 1'b1;
            if (key_valid && first_valid < 0) first_valid = cyc;
            key_ready = 1'b1;
            start = 1'b0;
            if (key_valid && stall_left == 0 && stall_seen == 0 && int'(key_round) == stall_round) begin
                stall_left = 5; held_key = key_out; held_round = key_round;
            end
            if (stall_left > 0) begin
                key_ready = 1'b0;
                if (key_out !== held_key || key_round !== held_round || !key_valid) stall_bad++;
                if (stall_left == 3) start = 1'b1;
                stall_left--;
                if (stall_left == 0) stall_seen = 1;
            end
            if (key_valid && int'(key_round) == drop_round && generation_done) begin
                generation_done = 1'b0; key_ready = 1'b0; drop_cyc = cyc;
            end
            if (key_valid && key_ready) begin
                if (n_hs < 16) begin
                    got_key[n_hs] = key_out; got_round[n_hs] = key_round; got_last[n_hs] = key_last;
                end
                n_hs++;
                last_hs = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        finished = (tail >= 4) ? 1 : 0;
        check("run_terminates", 128'(finished), 128'd1);
    endtask

    task automatic check_table(input logic dec);
        int nl;
        for (int i = 0; i < 8; i++) begin
            if (vt[i].dec == dec) begin
                check($sformatf("tbl_round[%0d,%0d]", dec, vt[i].pos), 128'(got_round[vt[i].pos]), 128'(vt[i].round));
                check($sformatf("tbl_key[%0d,%0d]", dec, vt[i].pos), got_key[vt[i].pos], vt[i].key);
                check($sformatf("tbl_last[%0d,%0d]", dec, vt[i].pos), 128'(got_last[vt[i].pos]), 128'(vt[i].last));
            end
        end
        nl = 0;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("order[%0d,%0d]", dec, i), 128'(got_round[i]), 128'(dec ? 10 - i : i));
            if (got_last[i]) nl++;
        end
        check("last_count", 128'(nl), 128'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;

        vt[0] = '{1'b0, 0,  4'd0,  K0,              1'b0};
        vt[1] = '{1'b0, 1,  4'd1,  {16{8'h01}},     1'b0};
        vt[2] = '{1'b0, 5,  4'd5,  {16{8'h05}},     1'b0};
        vt[3] = '{1'b0, 10, 4'd10, {16{8'h0a}},     1'b1};
        vt[4] = '{1'b1, 0,  4'd10, {16{8'h0a}},     1'b0};
        vt[5] = '{1'b1, 1,  4'd9,  {16{8'h09}},     1'b0};
        vt[6] = '{1'b1, 9,  4'd1,  {16{8'h01}},     1'b0};
        vt[7] = '{1'b1, 10, 4'd0,  K0,              1'b1};

        // Reset state.
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; generation_done = 1'b1; key_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_key_valid", 128'(key_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_key_out", key_out, 128'd0);
        check("rst_key_round", 128'(key_round), 128'd0);
        check("rst_read_addr", 128'(read_addr), 128'd0);
        check("rst_flags", 128'({key_last, seq_done, abort}), 128'd0);
        rst = 1'b0;

        // Reset while a key is presented and stalled.
        @(negedge clk);
        decrypt = 1'b0; start = 1'b1; key_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!key_valid && n < 10) begin @(negedge clk); n++; end
        check("midrst_presenting", 128'(key_valid), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_key_valid", 128'(key_valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_key_out", key_out, 128'd0);

        // Encrypt, ready always high.
        run_seq(1'b0, -1, -1);
        check("enc_busy_c1", 128'(busy_c1), 128'd1);
        check("enc_n_keys", 128'(n_hs), 128'd11);
        check("enc_first_valid_cyc", 128'(first_valid), 128'd3);
        check("enc_last_hs_cyc", 128'(last_hs), 128'(LAST_HS_CYC));
        check("enc_seq_done_pulses", 128'(n_done), 128'd1);
        check("enc_no_abort", 128'(n_abort), 128'd0);
        check("enc_busy_after", 128'(busy), 128'd0);
        check_table(1'b0);

        // Decrypt.
        run_seq(1'b1, -1, -1);
        check("dec_n_keys", 128'(n_hs), 128'd11);
        check("dec_first_valid_cyc", 128'(first_valid), 128'd3);
        check("dec_seq_done_pulses", 128'(n_done), 128'd1);
        check_table(1'b1);

        // Start before the schedule exists: wait 20 cycles, then release.
        generation_done = 1'b0;
        @(negedge clk);
        decrypt = 1'b0; start = 1'b1; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1 || key_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("waitgen_hold", 128'(bad), 128'd0);
        generation_done = 1'b1;
        // generation_done sampled on the first edge; key_valid two cycles after it.
        n = 0;
        do begin @(negedge clk); n++; end while (!key_valid && n < 10);
        check("waitgen_latency_edges", 128'(n), 128'd3);
        n = 0;
        while (!seq_done && n < 100) begin @(negedge clk); n++; end
        check("waitgen_completes", 128'(seq_done), 128'd1);
        @(negedge clk);

        // Backpressure on round 3 with a start pulse during the stall.
        run_seq(1'b0, 3, -1);
        check("bp_stall_seen", 128'(stall_seen), 128'd1);
        check("bp_stable", 128'(stall_bad), 128'd0);
        check("bp_n_keys", 128'(n_hs), 128'd11);
        check("bp_seq_done_pulses", 128'(n_done), 128'd1);
        check("bp_no_restart", 128'(valid_late), 128'd0);
        check_table(1'b0);

        // generation_done drops while round 6 is presented.
        run_seq(1'b0, -1, 6);
        check("abort_pulses", 128'(n_abort), 128'd1);
        check("abort_delay", 128'(abort_cyc - drop_cyc), 128'd1);
        check("abort_key_valid", 128'(abort_kv), 128'd0);
        check("abort_busy", 128'(abort_busy), 128'd0);
        check("abort_no_seq_done", 128'(n_done), 128'd0);
        check("abort_keys_before", 128'(n_hs), 128'd6);
        check("abort_abort_cleared", 128'(abort), 128'd0);
        check("abort_quiet", 128'(valid_late), 128'd0);
        generation_done = 1'b1;

        // Back in IDLE: a fresh decrypt sequence runs normally.
        run_seq(1'b1, -1, -1);
        check("post_abort_n_keys", 128'(n_hs), 128'd11);
        check("post_abort_first_key", got_key[0], {16{8'h0a}});
        check("post_abort_seq_done", 128'(n_done), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
